apb_arbiter_master: RTL
=======================

APB_ARBITER_MASTER -- requirements
Module: apb_arbiter_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, APB address width.
REQ-002 SHALL have parameter DATA_W, default 8, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, ACCESS-phase wait limit (used only when APB_TIMEOUT_EN is defined).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have ports reqN_valid, N=0,1  input  1  requester N has a transfer pending.
REQ-007 SHALL have ports reqN_write  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports reqN_addr  input  ADDR_W  and reqN_wdata  input  DATA_W  transfer payload.
REQ-009 SHALL have ports reqN_ready  output  1  request accepted this cycle (valid && ready).
REQ-010 SHALL have ports rspN_valid  output  1, rspN_rdata  output  DATA_W, rspN_err  output  1  one-cycle completion to requester N.
REQ-011 SHALL have APB master ports psel, penable, pwrite  output  1; paddr  output  ADDR_W; pwdata  output  DATA_W.
REQ-012 SHALL have APB slave-return ports prdata  input  DATA_W; pready, pslverr  input  1.

Function
REQ-013 SHALL implement states IDLE, SETUP, ACCESS, RESP; one transfer in flight at a time.
REQ-014 In IDLE, reqN_ready SHALL be driven combinationally high only for the arbitration winner among asserted reqN_valid; both low if none valid.
REQ-015 Arbitration SHALL be round-robin: with both valid, the requester not granted last wins; with one valid, it wins regardless of the pointer.
REQ-016 On acceptance the block SHALL register owner, write, addr, wdata, update the last-grant pointer, and go to SETUP.
REQ-017 SETUP SHALL last exactly one cycle with psel=1, penable=0, paddr/pwrite/pwdata from the captured payload; then ACCESS.
REQ-018 ACCESS SHALL drive psel=1, penable=1 with stable address/control/data until a cycle with pready=1.
REQ-019 On pready=1 in ACCESS, the block SHALL capture prdata (zero for writes) and pslverr, and go to RESP.
REQ-020 RESP SHALL last one cycle: psel=penable=0, rspN_valid=1 for the owner only with captured rdata/err; then IDLE.
REQ-021 Minimum latency: accept cycle T, SETUP T+1, ACCESS T+2, rsp valid T+3 when pready is high at T+2; back-to-back throughput one transfer per 4 cycles.
REQ-022 reqN_* inputs SHALL be ignored outside IDLE; payload changes after acceptance SHALL not affect the APB bus.
REQ-023 psel, penable SHALL be 0 in IDLE and RESP; rsp*_rdata/err SHALL hold last values when rsp*_valid=0.

Reset
REQ-024 With rst_n=0 at a rising edge, the block SHALL enter IDLE; psel, penable, pwrite, paddr, pwdata, all reqN_ready-registered state, rspN_valid, rspN_rdata, rspN_err SHALL be 0; pointer SHALL favour req0 first.
REQ-025 Reset mid-transfer (SETUP/ACCESS/RESP) SHALL abort it at that edge with no rsp pulse to either requester.

Configuration
REQ-026 Macro APB_TIMEOUT_EN SHALL gate an ACCESS-phase watchdog.
REQ-027 With APB_TIMEOUT_EN defined: a counter cleared on entry to ACCESS counts cycles with pready=0; on reaching TIMEOUT_CYCLES the block SHALL go to RESP with rspN_err=1, rspN_rdata=0; pready in that same cycle takes priority (normal completion).
REQ-028 Without APB_TIMEOUT_EN: no counter logic; ACCESS waits indefinitely for pready.

Verification
REQ-029 req0 write addr=0x12 wdata=0xA5, pready=1 -> psel T+1..T+2, penable T+2, rsp0_valid at T+3, rsp0_err=0, rsp1_valid never.
REQ-030 Both valid from reset, each reads, prdata 0x11 then 0x22 -> req0 served first (rsp0_rdata=0x11), then req1 (rsp1_rdata=0x22); repeated both-valid alternates 0,1,0,1.
REQ-031 req1 read, pready held low 5 cycles then pready=1 pslverr=1 prdata=0x7E -> penable high 6 cycles, paddr stable, rsp1_valid with rdata=0x7E, err=1.
REQ-032 APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready stuck 0 -> ACCESS exits after 16 cycles, rsp0_err=1, rsp0_rdata=0; without macro, penable stays 1 for 100+ cycles.
REQ-033 rst_n=0 asserted during ACCESS -> next edge psel=penable=0, state IDLE, no rspN_valid; subsequent req1-only request accepted immediately.

Source files
------------

// File: rtl/apb_arbiter_master_if.sv
// APB bus bundle between the arbiter (master side) and one APB completer.
// Transfer qualification: a beat completes on the cycle where psel && penable && pready.
interface apb_arbiter_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_arbiter_master.sv
// Two-requester round-robin arbiter driving a single APB master port.
// Optional ACCESS-phase watchdog enabled by defining APB_TIMEOUT_EN.
module apb_arbiter_master #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  // Requester handshake: a request is taken on a cycle with reqN_valid && reqN_ready.
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  apb_arbiter_master_if.master apb,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rsp0_rdata_q, rsp0_rdata_d;
  logic [DATA_W-1:0] rsp1_rdata_q, rsp1_rdata_d;
  logic              rsp0_err_q, rsp0_err_d;
  logic              rsp1_err_q, rsp1_err_d;
  logic              gnt0, gnt1;

`ifdef APB_TIMEOUT_EN
  localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // last_q holds the most recently granted requester; req1 wins a tie only after req0 was served.
  always_comb begin
    gnt1 = req1_valid && (!req0_valid || !last_q);
    gnt0 = req0_valid && !gnt1;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rsp0_rdata_d = rsp0_rdata_q;
    rsp1_rdata_d = rsp1_rdata_q;
    rsp0_err_d   = rsp0_err_q;
    rsp1_err_d   = rsp1_err_q;
`ifdef APB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          owner_d = gnt1;
          last_d  = gnt1;
          wr_d    = gnt1 ? req1_write : req0_write;
          addr_d  = gnt1 ? req1_addr  : req0_addr;
          wdata_d = gnt1 ? req1_wdata : req0_wdata;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
`ifdef APB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ACCESS: begin
        if (apb.pready) begin
          if (owner_q) begin
            rsp1_rdata_d = wr_q ? '0 : apb.prdata;
            rsp1_err_d   = apb.pslverr;
          end else begin
            rsp0_rdata_d = wr_q ? '0 : apb.prdata;
            rsp0_err_d   = apb.pslverr;
          end
          state_d = RESP;
        end
`ifdef APB_TIMEOUT_EN
        // A stalled completer is abandoned and reported as an error with no data.
        else if (cnt_q == TO_LAST) begin
          if (owner_q) begin
            rsp1_rdata_d = '0;
            rsp1_err_d   = 1'b1;
          end else begin
            rsp0_rdata_d = '0;
            rsp0_err_d   = 1'b1;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
      rsp0_err_q   <= 1'b0;
      rsp1_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
      rsp0_err_q   <= rsp0_err_d;
      rsp1_err_q   <= rsp1_err_d;
`ifdef APB_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  always_comb begin
    req0_ready  = (state_q == IDLE) && gnt0;
    req1_ready  = (state_q == IDLE) && gnt1;
    apb.psel    = (state_q == SETUP) || (state_q == ACCESS);
    apb.penable = (state_q == ACCESS);
    apb.pwrite  = wr_q;
    apb.paddr   = addr_q;
    apb.pwdata  = wdata_q;
    rsp0_valid  = (state_q == RESP) && !owner_q;
    rsp1_valid  = (state_q == RESP) && owner_q;
    rsp0_rdata  = rsp0_rdata_q;
    rsp1_rdata  = rsp1_rdata_q;
    rsp0_err    = rsp0_err_q;
    rsp1_err    = rsp1_err_q;
    dbg_state   = state_q;
  end

endmodule
